// File: rtl/register_file_pkg.sv
// Shared types, enable constants and the byte-lane merge used by register_file.
// The merge serves both the write path and the REGISTER_FILE_BYPASS_EN forwarding path.
package register_file_pkg;

  typedef enum logic {
    STATE_CLEAR,
    STATE_READY
  } state_t;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  // Widest supported register; callers zero-extend into and truncate out of this width.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_LANES      = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] merge_lanes(
    input logic [MAX_DATA_WIDTH-1:0] old_value,
    input logic [MAX_DATA_WIDTH-1:0] new_value,
    input logic [MAX_LANES-1:0]      mask
  );
    logic [MAX_DATA_WIDTH-1:0] result;
    result = old_value;
    for (int b = 0; b < MAX_LANES; b++) begin
      if (mask[b]) begin
        result[b*8 +: 8] = new_value[b*8 +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: zero/enable/ready gating and, when
// REGISTER_FILE_BYPASS_EN is defined, same-cycle forwarding of the write port.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    ready,
  input  logic                    clear,
  input  logic                    read_enable,
  input  logic [ADDR_WIDTH-1:0]   read_address,
  input  logic [DATA_WIDTH-1:0]   entry,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH/8-1:0] write_mask,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data
);

  always_comb begin
    read_data = '0;
    if (ready && (read_enable == READ_ENABLE) && (read_address != '0)) begin
      read_data = entry;
`ifdef REGISTER_FILE_BYPASS_EN
      // A nonzero read address matching the write address implies the write targets a real entry.
      if ((write_enable == WRITE_ENABLE) && !clear && (write_address == read_address)) begin
        read_data = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(entry),
                                            MAX_DATA_WIDTH'(write_data),
                                            MAX_LANES'(write_mask)));
      end
`endif
    end
  end

`ifndef REGISTER_FILE_BYPASS_EN
  logic unused_write_port;
  assign unused_write_port = ^{write_enable, write_address, write_mask, write_data, clear};
`endif

endmodule

// File: rtl/register_file.sv
// Parametrised register file with byte-masked write, scrub-to-zero engine and
// READ_PORTS read ports; REGISTER_FILE_BYPASS_EN enables write-to-read forwarding.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  output logic                             ready,
  input  logic [READ_PORTS-1:0]            read_enable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH/8-1:0]          write_mask,
  input  logic [DATA_WIDTH-1:0]            write_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] storage [DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] count;
  logic                  write_accept;

  assign write_accept = ready && (write_enable == WRITE_ENABLE) && !clear &&
                        (write_address != '0);

  // Scrub sequencer: count walks 1..DEPTH-1, and the last entry (all ones) hands over to READY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= STATE_CLEAR;
      count <= ADDR_WIDTH'(1);
      ready <= 1'b0;
    end else if (clear) begin
      state <= STATE_CLEAR;
      count <= ADDR_WIDTH'(1);
      ready <= 1'b0;
    end else begin
      case (state)
        STATE_CLEAR: begin
          if (count == '1) begin
            state <= STATE_READY;
            ready <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        STATE_READY: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage is deliberately unreset; entry 0 is never written and is masked on read.
  always_ff @(posedge clock) begin
    if (state == STATE_CLEAR) begin
      storage[count] <= '0;
    end else if (write_accept) begin
      storage[write_address] <= DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(storage[write_address]),
                                                        MAX_DATA_WIDTH'(write_data),
                                                        MAX_LANES'(write_mask)));
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read_port
    register_file_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port (
      .ready         (ready),
      .clear         (clear),
      .read_enable   (read_enable[p]),
      .read_address  (read_address[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .entry         (storage[read_address[p*ADDR_WIDTH +: ADDR_WIDTH]]),
      .write_enable  (write_enable),
      .write_address (write_address),
      .write_mask    (write_mask),
      .write_data    (write_data),
      .read_data     (read_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic
// compared against an array-based model of the register file.
module tb_register_file;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int RP    = 2;
  localparam int DEPTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic             ready;
  logic [RP-1:0]    read_enable;
  logic [RP*AW-1:0] read_address;
  logic [RP*DW-1:0] read_data;
  logic             write_enable;
  logic [AW-1:0]    write_address;
  logic [DW/8-1:0]  write_mask;
  logic [DW-1:0]    write_data;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_ready;
  int            scrub_left;
  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [DW-1:0] same_cycle_expected;

  register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_PORTS(RP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .ready         (ready),
    .read_enable   (read_enable),
    .read_address  (read_address),
    .read_data     (read_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_mask    (write_mask),
    .write_data    (write_data)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_value,
                                               input logic [DW-1:0] new_value,
                                               input logic [DW/8-1:0] mask);
    logic [DW-1:0] r;
    r = old_value;
    for (int b = 0; b < DW/8; b++) if (mask[b]) r[b*8 +: 8] = new_value[b*8 +: 8];
    return r;
  endfunction

  // Scrub restart: the file is unusable for DEPTH-1 edges and afterwards holds all zeros.
  task automatic model_reset();
    model_ready = 1'b0;
    scrub_left  = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic model_edge();
    if (!reset || clear) begin
      model_reset();
    end else if (!model_ready) begin
      scrub_left--;
      if (scrub_left == 0) model_ready = 1'b1;
    end else if (write_enable && write_address != 0) begin
      model_mem[write_address] = lane_merge(model_mem[write_address], write_data, write_mask);
    end
  endtask

  function automatic logic [DW-1:0] expected_read(input int p);
    logic [AW-1:0] addr;
    logic [DW-1:0] v;
    addr = read_address[p*AW +: AW];
    if (!model_ready || !read_enable[p] || addr == 0) return '0;
    v = model_mem[addr];
`ifdef REGISTER_FILE_BYPASS_EN
    if (write_enable && !clear && write_address == addr)
      v = lane_merge(v, write_data, write_mask);
`endif
    return v;
  endfunction

  task automatic check_value(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_output();
    check_value("ready", 32'(ready), 32'(model_ready));
    for (int p = 0; p < RP; p++)
      check_value($sformatf("read_data[%0d]", p), read_data[p*DW +: DW], expected_read(p));
  endtask

  task automatic apply_stimulus(input logic we, input logic [AW-1:0] wa,
                                input logic [DW/8-1:0] wm, input logic [DW-1:0] wd,
                                input logic [RP-1:0] re, input logic [AW-1:0] ra0,
                                input logic [AW-1:0] ra1, input logic clr);
    write_enable  = we;
    write_address = wa;
    write_mask    = wm;
    write_data    = wd;
    read_enable   = re;
    read_address  = {ra1, ra0};
    clear         = clr;
  endtask

  task automatic half();
    @(negedge clock);
    check_output();
  endtask

  task automatic edge_step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic tick();
    half();
    edge_step();
  endtask

  // Counts DEPTH-1 edges from the current point and checks the exact ready boundary.
  task automatic scrub_wait(input string tag);
    for (int i = 1; i <= DEPTH - 1; i++) begin
      half();
      if (i == DEPTH - 1) check_value({tag, "_ready_low_at_30"}, 32'(ready), 32'd0);
      edge_step();
    end
    half();
    check_value({tag, "_ready_high_at_31"}, 32'(ready), 32'd1);
    edge_step();
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, '0, '0, '0, 2'b11, 5'd1, 5'd2, 1'b0);
    model_reset();
    repeat (3) tick();

    reset = 1'b1;
    scrub_wait("reset_release");
    for (int i = 1; i < DEPTH; i++) begin
      apply_stimulus(1'b0, '0, '0, '0, 2'b11, 5'(i), 5'(DEPTH - i), 1'b0);
      half();
      check_value("scrubbed_entry", read_data[0 +: DW], '0);
      edge_step();
    end

    apply_stimulus(1'b1, 5'd3, 4'hF, 32'hDEADBEEF, 2'b00, '0, '0, 1'b0);
    tick();
    apply_stimulus(1'b1, 5'd3, 4'h1, 32'h00000011, 2'b01, 5'd3, '0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, '0, 2'b01, 5'd3, '0, 1'b0);
    half();
    check_value("masked_write", read_data[0 +: DW], 32'hDEADBE11);
    edge_step();

    apply_stimulus(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, '0, 2'b11, 5'd0, 5'd0, 1'b0);
    half();
    check_value("addr0_port0", read_data[0 +: DW], '0);
    check_value("addr0_port1", read_data[DW +: DW], '0);
    edge_step();

    apply_stimulus(1'b1, 5'd7, 4'hF, 32'h12345678, 2'b00, '0, '0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, '0, 2'b11, 5'd7, 5'd7, 1'b0);
    half();
    check_value("shared_port0", read_data[0 +: DW], 32'h12345678);
    check_value("shared_port1", read_data[DW +: DW], 32'h12345678);
    edge_step();

`ifdef REGISTER_FILE_BYPASS_EN
    same_cycle_expected = 32'hA5A5A5A5;
`else
    same_cycle_expected = 32'h00000000;
`endif
    apply_stimulus(1'b1, 5'd5, 4'hF, 32'hA5A5A5A5, 2'b11, 5'd5, 5'd5, 1'b0);
    half();
    check_value("same_cycle_read", read_data[DW +: DW], same_cycle_expected);
    edge_step();
    apply_stimulus(1'b0, '0, '0, '0, 2'b11, 5'd5, 5'd7, 1'b0);
    half();
    check_value("next_cycle_read", read_data[0 +: DW], 32'hA5A5A5A5);
    edge_step();

    apply_stimulus(1'b0, '0, '0, '0, 2'b11, 5'd7, 5'd5, 1'b0);
    half();
    #1 reset = 1'b0;
    model_reset();
    #1;
    check_value("async_reset_ready", 32'(ready), 32'd0);
    check_value("async_reset_read", read_data[0 +: DW], '0);
    edge_step();
    reset = 1'b1;
    scrub_wait("async_reset");

    apply_stimulus(1'b1, 5'd9, 4'hF, 32'h0BADF00D, 2'b00, '0, '0, 1'b0);
    tick();
    apply_stimulus(1'b1, 5'd9, 4'hF, 32'hFFFFFFFF, 2'b00, '0, '0, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, '0, 2'b01, 5'd9, '0, 1'b0);
    scrub_wait("clear");
    half();
    check_value("clear_drops_write", read_data[0 +: DW], '0);
    edge_step();

    apply_stimulus(1'b0, '0, '0, '0, 2'b00, '0, '0, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, '0, 2'b11, 5'd7, 5'd12, 1'b0);
    repeat (11) tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_value("mid_scrub_reset_ready", 32'(ready), 32'd0);
    check_value("mid_scrub_reset_read", read_data[DW +: DW], '0);
    edge_step();
    reset = 1'b1;
    scrub_wait("mid_scrub_reset");

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa;
      wa = 5'($urandom_range(0, 7));
      apply_stimulus($urandom_range(0, 3) != 0, wa, 4'($urandom_range(0, 15)), $urandom,
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)),
                     $urandom_range(0, 99) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
